// File: rtl/tpu_pkg.sv
// Shared drain-path types: FSM encoding, output buffer depth and a row clamp helper.
package tpu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } drain_state_e;

    // Entries in the GLB-side skid buffer; the read throttle assumes exactly this many.
    localparam int unsigned SKID_DEPTH = 2;

    // Requested rows beyond what the accumulation FIFO can hold are not drained.
    function automatic int unsigned clamp_rows(input int unsigned rows, input int unsigned depth);
        return (rows > depth) ? depth : rows;
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry FIFO-ordered skid buffer between the accumulation FIFO read data and the GLB port.
module drain_skid_buf
    import tpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Handshakes; head entry always drives the output.
    always_comb begin
        in_ready  = (count < 2'(SKID_DEPTH));
        out_valid = (count != 2'd0);
        out_data  = head;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Head/tail storage with shift-on-pop so the head stays the oldest row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) head <= in_data;
                end
                2'd1: begin
                    if (push && pop) head <= in_data;
                    else if (push)   tail <= in_data;
                end
                default: begin
                    if (pop) head <= tail;
                end
            endcase
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Drains accumulated psum rows from the per-column FIFOs into consecutive GLB words.
module acc_drain
    import tpu_pkg::*;
#(
    parameter int unsigned PE_SIZE    = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [$clog2(FIFO_DEPTH):0]      row_cnt_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    output logic [PE_SIZE-1:0]               rden_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0]    psum_row_i,
    output logic                             glb_wren_o,
    input  logic                             glb_ready_i,
    output logic [ADDR_WIDTH-1:0]            glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0]    glb_wdata_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ROW_W = DATA_WIDTH * PE_SIZE;

    drain_state_e     state;
    logic [CNT_W-1:0] rd_left;
    logic             rd_inflight;
    logic [CNT_W-1:0] start_rows;
    logic             start_ok;
    logic             buf_in_ready;
    logic             wr_accept;
    logic [1:0]       occ;
    logic [2:0]       pending;
    logic             rd_en;

    // Read throttle: a read issued now lands after the next edge, so rows held after this
    // cycle's write plus the row already in flight must leave room for it.
    always_comb begin
        start_ok   = start_i && (state == StIdle);
        start_rows = CNT_W'(clamp_rows(int'(row_cnt_i), FIFO_DEPTH));
        wr_accept  = glb_wren_o & glb_ready_i;
        occ        = !glb_wren_o ? 2'd0 : (buf_in_ready ? 2'd1 : 2'd2);
        pending    = 3'(occ) - 3'(wr_accept) + 3'(rd_inflight);
        rd_en      = (state == StDrain) && (rd_left != '0) && (pending < 3'(SKID_DEPTH));
        rden_o     = {PE_SIZE{rd_en}};
    end

    // Drain sequencer: read issue count, in-flight tracking and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            rd_left     <= '0;
            rd_inflight <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            rd_inflight <= rd_en;
            case (state)
                StIdle: begin
                    if (start_ok) begin
                        busy_o  <= 1'b1;
                        rd_left <= start_rows;
                        if (start_rows != '0) begin
                            state <= StDrain;
                        end else begin
                            state  <= StDone;
                            done_o <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (rd_en) begin
                        rd_left <= rd_left - CNT_W'(1);
                        if (rd_left == CNT_W'(1)) state <= StFlush;
                    end
                end
                StFlush: begin
                    // Buffer empties on this edge and nothing left to capture.
                    if (pending == 3'd0) begin
                        state  <= StDone;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= StIdle;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    // GLB word address: loaded on an accepted start, advanced per accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glb_addr_o <= '0;
        end else if (start_ok) begin
            glb_addr_o <= base_addr_i;
        end else if (wr_accept) begin
            glb_addr_o <= glb_addr_o + ADDR_WIDTH'(1);
        end
    end

    drain_skid_buf #(
        .WIDTH (ROW_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_inflight),
        .in_ready  (buf_in_ready),
        .in_data   (psum_row_i),
        .out_valid (glb_wren_o),
        .out_ready (glb_ready_i),
        .out_data  (glb_wdata_o)
    );

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: emulated accumulation FIFO, queue-based expected-write model.
module tb_acc_drain;

    localparam int PE = 16;
    localparam int DW = 32;
    localparam int FD = 64;
    localparam int AW = 16;
    localparam int CW = $clog2(FD) + 1;
    localparam int RW = DW * PE;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] row_cnt_i;
    logic [AW-1:0] base_addr_i;
    logic [PE-1:0] rden_o;
    logic [RW-1:0] psum_row_i;
    logic          glb_wren_o;
    logic          glb_ready_i;
    logic [AW-1:0] glb_addr_o;
    logic [RW-1:0] glb_wdata_o;
    logic          busy_o;
    logic          done_o;

    acc_drain #(
        .PE_SIZE    (PE),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .row_cnt_i   (row_cnt_i),
        .base_addr_i (base_addr_i),
        .rden_o      (rden_o),
        .psum_row_i  (psum_row_i),
        .glb_wren_o  (glb_wren_o),
        .glb_ready_i (glb_ready_i),
        .glb_addr_o  (glb_addr_o),
        .glb_wdata_o (glb_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Emulated accumulation FIFO contents and the expected GLB write stream.
    logic [RW-1:0] fifo_q[$];
    logic [RW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int            exp_n;

    // Observations logged per run.
    int            rd_seen, wr_seen, stall_seen, rd_first, done_cyc;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_col0[$];
    int            log_cyc[$];
    logic          rd_req = 1'b0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [RW-1:0] prev_data;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Row k of run 'tag': column c holds tag<<16 | k<<8 | c, column 0 in the MSBs.
    function automatic logic [RW-1:0] mk_row(input int tag, input int k);
        logic [RW-1:0] r;
        for (int c = 0; c < PE; c++) r[(PE-1-c)*DW +: DW] = DW'(tag * 65536 + k * 256 + c);
        return r;
    endfunction

    // One clock; the FIFO presents the popped row the cycle after rden_o was high.
    task automatic step();
        @(posedge clk);
        #1;
        if (rd_req) psum_row_i = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every cycle out of reset, DUT outputs against the expected stream.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rd_req     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            rd_req = rden_o[0];
            chk("rden_uniform", (rden_o == '0) || (rden_o == '1), 1);
            if (rden_o[0]) begin
                rd_seen++;
                if (rd_seen == 1) rd_first = cyc;
                chk("rden_within_count", rd_seen <= exp_n, 1);
            end
            if (prev_stall) begin
                chk("stall_addr_stable", glb_addr_o, prev_addr);
                chk("stall_data_stable", glb_wdata_o, prev_data);
            end
            if (glb_wren_o && glb_ready_i) begin
                wr_seen++;
                chk("write_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    chk("write_data", glb_wdata_o, exp_data.pop_front());
                    chk("write_addr", glb_addr_o, exp_addr.pop_front());
                end
                log_addr.push_back(glb_addr_o);
                log_col0.push_back(glb_wdata_o[RW-1 -: DW]);
                log_cyc.push_back(cyc);
            end
            if (glb_wren_o && !glb_ready_i) stall_seen++;
            prev_stall = glb_wren_o && !glb_ready_i;
            prev_addr  = glb_addr_o;
            prev_data  = glb_wdata_o;
            if (done_o) begin
                done_cyc = cyc;
                chk("done_all_written", exp_data.size(), 0);
                chk("done_read_count", rd_seen, exp_n);
            end
        end
    end

    // One drain request. Cycle 'rel' counts edges since the cycle start_i was driven in;
    // ready is low for rel in [stall_lo, stall_hi], extra starts are poked at poke_a/poke_b,
    // and rst is raised at rel == rst_at (negative values disable each option).
    task automatic run_drain(input int tag, input int cnt, input logic [AW-1:0] base,
                             input int stall_lo, input int stall_hi,
                             input int poke_a, input int poke_b, input int rst_at,
                             output int s);
        int  n;
        int  rel;
        bit  fin;
        fifo_q.delete(); exp_data.delete(); exp_addr.delete();
        log_addr.delete(); log_col0.delete(); log_cyc.delete();
        for (int k = 1; k <= cnt; k++) fifo_q.push_back(mk_row(tag, k));
        n = (cnt > FD) ? FD : cnt;
        exp_n = n;
        for (int k = 0; k < n; k++) begin
            exp_data.push_back(mk_row(tag, k + 1));
            exp_addr.push_back(AW'(int'(base) + k));
        end
        rd_seen = 0; wr_seen = 0; stall_seen = 0; rd_first = -1; done_cyc = -1;
        step();
        glb_ready_i = 1'b1;
        s           = cyc;
        start_i     = 1'b1;
        row_cnt_i   = CW'(cnt);
        base_addr_i = base;
        fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            step();
            rel         = cyc - s;
            start_i     = (rel == poke_a) || (rel == poke_b);
            row_cnt_i   = CW'(9);
            base_addr_i = 16'h2000;
            glb_ready_i = !(rel >= stall_lo && rel <= stall_hi);
            if (rel == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_rden", rden_o, 0);
                chk("rst_wren", glb_wren_o, 0);
                chk("rst_addr", glb_addr_o, 0);
                chk("rst_wdata", glb_wdata_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                fifo_q.delete(); exp_data.delete(); exp_addr.delete();
                exp_n = 0; rd_seen = 0;
                step(); step();
                rst = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    step();
                    @(negedge clk);
                    chk("post_rst_idle", {busy_o, done_o, glb_wren_o, rden_o[0]}, 0);
                end
                fin = 1;
            end
            @(negedge clk);
            if (!fin) chk("busy_while_draining", busy_o, 1);
            if (done_o) fin = 1;
        end
        chk("drain_finished", fin, 1);
        step();
        start_i     = 1'b0;
        glb_ready_i = 1'b1;
        @(negedge clk);
        chk("idle_after_done", {busy_o, done_o}, 0);
    endtask

    // Watchdog so a wedged DUT still ends the run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1; start_i = 1'b0; row_cnt_i = '0; base_addr_i = '0;
        psum_row_i = '0; glb_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rden", rden_o, 0);
        chk("reset_wren", glb_wren_o, 0);
        chk("reset_addr", glb_addr_o, 0);
        chk("reset_wdata", glb_wdata_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        rst = 1'b0;

        // Four rows at full rate: reads rel 1..4, writes rel 3..6, done at rel 7.
        run_drain(1, 4, 16'h0100, -1, -1, -1, -1, -1, s);
        chk("t1_rd_count", rd_seen, 4);
        chk("t1_first_rden", rd_first - s, 1);
        chk("t1_first_write", log_cyc[0] - s, 3);
        chk("t1_last_write", log_cyc[3] - s, 6);
        chk("t1_done", done_cyc - s, 7);
        chk("t1_addr0", log_addr[0], 16'h0100);
        chk("t1_addr3", log_addr[3], 16'h0103);
        chk("t1_col0_row4", log_col0[3], 32'h0001_0400);

        // Eight rows, GLB stalls for four cycles with a row waiting.
        run_drain(2, 8, 16'h0200, 3, 6, -1, -1, -1, s);
        chk("t2_rd_count", rd_seen, 8);
        chk("t2_wr_count", wr_seen, 8);
        chk("t2_stalls", stall_seen, 4);
        chk("t2_addr7", log_addr[7], 16'h0207);
        chk("t2_col0_row8", log_col0[7], 32'h0002_0800);

        // Zero rows: no traffic, done on the following cycle.
        run_drain(3, 0, 16'h0300, -1, -1, -1, -1, -1, s);
        chk("t3_rd_count", rd_seen, 0);
        chk("t3_wr_count", wr_seen, 0);
        chk("t3_done", done_cyc - s, 1);

        // Address wrap.
        run_drain(4, 3, 16'hFFFE, -1, -1, -1, -1, -1, s);
        chk("t4_wr_count", wr_seen, 3);
        chk("t4_addr0", log_addr[0], 16'hFFFE);
        chk("t4_addr1", log_addr[1], 16'hFFFF);
        chk("t4_addr2", log_addr[2], 16'h0000);

        // Starts during DRAIN and during DONE must be ignored.
        run_drain(5, 4, 16'h0100, -1, -1, 2, 7, -1, s);
        chk("t5_rd_count", rd_seen, 4);
        chk("t5_wr_count", wr_seen, 4);
        chk("t5_done", done_cyc - s, 7);
        chk("t5_addr0", log_addr[0], 16'h0100);

        // Reset in the middle of a drain.
        run_drain(6, 8, 16'h0400, -1, -1, -1, -1, 3, s);

        // Oversized request clamps to the FIFO depth.
        run_drain(7, 100, 16'h1000, -1, -1, -1, -1, -1, s);
        chk("t7_rd_count", rd_seen, 64);
        chk("t7_wr_count", wr_seen, 64);
        chk("t7_last_addr", log_addr[63], 16'h103F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
